// File: rtl/spi_slave_regbank.sv
// spi_slave_regbank
//   SPI slave with a write/readback register bank. The SPI pins are
//   oversampled on clk_12mhz. A frame is a command byte (bit7 = R/nW,
//   bits6:0 = address) followed by one or more W-bit data words.
//   Reads return reg[addr], status_in at addr == NUM_REGS, or zero with
//   frame_err for any higher address.
//
// Ports
//   clk_12mhz    system clock
//   rst          asynchronous reset, active-high
//   spi_clk      SPI SCK (asynchronous to clk_12mhz)
//   spi_mosi     SPI data in, MSB first
//   spi_cs       chip select, active-low
//   spi_miso     SPI data out, MSB first
//   spi_miso_oe  high while the synchronised CS is low
//   status_in    read-only word returned at address NUM_REGS
//   reg_flat     register bank, reg[i] = reg_flat[i*W +: W]
//   wr_strobe    one-cycle pulse when a register is written
//   wr_addr      address of the last write, valid with wr_strobe
//   frame_err    one-cycle pulse on any frame error
module spi_slave_regbank #(
  parameter int                      DATA_BYTES  = 1,
  parameter int                      NUM_REGS    = 16,
  parameter logic [8*DATA_BYTES-1:0] RESET_VAL   = '0,
  parameter bit                      CPOL        = 1'b0,
  parameter bit                      CPHA        = 1'b0,
  parameter bit                      AUTO_INC    = 1'b0,
  parameter int                      SYNC_STAGES = 2
) (
  input  logic                             clk_12mhz,
  input  logic                             rst,
  input  logic                             spi_clk,
  input  logic                             spi_mosi,
  input  logic                             spi_cs,
  output logic                             spi_miso,
  output logic                             spi_miso_oe,
  input  logic [8*DATA_BYTES-1:0]          status_in,
  output logic [NUM_REGS*8*DATA_BYTES-1:0] reg_flat,
  output logic                             wr_strobe,
  output logic [6:0]                       wr_addr,
  output logic                             frame_err
);

  localparam int         W  = 8 * DATA_BYTES;
  localparam int         CW = $clog2(W + 1);
  localparam int         AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [6:0] NR = 7'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_HOLD,
    S_IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
  logic                   sck_prev, cs_prev;
  logic [CW-1:0]          bit_cnt;
  logic [W-2:0]           rx_shift;
  logic [W-1:0]           tx_shift;
  logic                   rw;
  logic [6:0]             addr;
  logic                   load_tx;
  logic [W-1:0]           regs [NUM_REGS];

  logic       sck_s, mosi_s, cs_s;
  logic       sck_rise, sck_fall, sample_edge, shift_edge;
  logic       cs_fall, cs_rise;
  logic [W-1:0] rx_next;
  logic       cmd_done, word_done, partial;
  logic [W-1:0] rd_word;
  logic       rd_bad;

  // Synchronisers reset to the idle levels so no false edge appears after reset.
  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      sck_sync  <= {SYNC_STAGES{CPOL}};
      mosi_sync <= '0;
      cs_sync   <= '1;
      sck_prev  <= CPOL;
      cs_prev   <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  assign sck_rise    = sck_s & ~sck_prev;
  assign sck_fall    = ~sck_s & sck_prev;
  assign sample_edge = (CPOL == CPHA) ? sck_rise : sck_fall;
  assign shift_edge  = (CPOL == CPHA) ? sck_fall : sck_rise;
  assign cs_fall     = cs_prev & ~cs_s;
  assign cs_rise     = ~cs_prev & cs_s;

  // MOSI and SCK pass the same number of stages, so mosi_s is aligned with the edge.
  assign rx_next   = {rx_shift, mosi_s};
  assign cmd_done  = (state == S_CMD) && sample_edge && (bit_cnt == CW'(7));
  assign word_done = (state == S_DATA) && sample_edge && (bit_cnt == CW'(W - 1));

  // A CS rise counts as an error only when some bits of a command or word are pending.
  assign partial = ((state == S_CMD)  && ((bit_cnt != '0) || sample_edge) && !cmd_done) ||
                   ((state == S_DATA) && ((bit_cnt != '0) || sample_edge) && !word_done);

  always_comb begin
    rd_word = '0;
    rd_bad  = 1'b0;
    if (addr < NR) begin
      rd_word = regs[addr[AW-1:0]];
    end else if (addr == NR) begin
      rd_word = status_in;
    end else begin
      rd_bad = 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_flat[g*W +: W] = regs[g];
  end

  // Frame FSM. The CS-rise handling sits last so it overrides the state,
  // while a word completing in the same cycle still commits its write.
  always_ff @(posedge clk_12mhz or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      rw          <= 1'b0;
      addr        <= '0;
      load_tx     <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      wr_strobe   <= 1'b0;
      wr_addr     <= '0;
      frame_err   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else begin
      wr_strobe   <= 1'b0;
      frame_err   <= 1'b0;
      load_tx     <= 1'b0;
      spi_miso_oe <= ~cs_s;

      // The reload lands one clock after the command/word completes, well before the next shift edge.
      if (load_tx) begin
        tx_shift <= rd_word;
        if (rd_bad) begin
          frame_err <= 1'b1;
        end
      end else if ((state == S_DATA) && shift_edge) begin
        spi_miso <= tx_shift[W-1];
        tx_shift <= tx_shift << 1;
      end

      case (state)
        S_IDLE: begin
          if (cs_fall) begin
            state    <= S_CMD;
            bit_cnt  <= '0;
            tx_shift <= '0;
            spi_miso <= 1'b0;
          end
        end
        S_CMD: begin
          if (sample_edge) begin
            rx_shift <= rx_next[W-2:0];
            if (cmd_done) begin
              rw      <= rx_next[7];
              addr    <= rx_next[6:0];
              bit_cnt <= '0;
              load_tx <= rx_next[7];
              state   <= S_DATA;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (sample_edge) begin
            rx_shift <= rx_next[W-2:0];
            if (word_done) begin
              bit_cnt <= '0;
              if (!rw) begin
                if (addr < NR) begin
                  regs[addr[AW-1:0]] <= rx_next;
                  wr_strobe          <= 1'b1;
                  wr_addr            <= addr;
                end else begin
                  frame_err <= 1'b1;
                end
              end
              if (AUTO_INC) begin
                addr    <= addr + 7'd1;
                load_tx <= rw;
              end else begin
                state <= S_HOLD;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (sample_edge) begin
            frame_err <= 1'b1;
            state     <= S_IGNORE;
          end
        end
        default: ;
      endcase

      if (cs_rise) begin
        state    <= S_IDLE;
        bit_cnt  <= '0;
        tx_shift <= '0;
        spi_miso <= 1'b0;
        load_tx  <= 1'b0;
        if (partial) begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regbank.sv
// tb_spi_slave_regbank
//   Directed bench for spi_slave_regbank. Instance A: W=8, mode 0, no
//   auto-increment. Instance B: W=16, mode 3, auto-increment. Both share
//   SCK and MOSI; each has its own chip select, so the idle instance
//   sees only SCK edges outside a frame.
module tb_spi_slave_regbank;

  localparam int H = 80;

  logic         clk_12mhz = 1'b0;
  logic         rst = 1'b1;
  logic         sck = 1'b0;
  logic         mosi = 1'b0;
  logic         cs_a = 1'b1;
  logic         cs_b = 1'b1;
  logic [7:0]   status_a = 8'h00;
  logic [15:0]  status_b = 16'hBEEF;

  logic         miso_a, miso_oe_a, wr_strobe_a, frame_err_a;
  logic [6:0]   wr_addr_a;
  logic [127:0] reg_flat_a;
  logic         miso_b, miso_oe_b, wr_strobe_b, frame_err_b;
  logic [6:0]   wr_addr_b;
  logic [255:0] reg_flat_b;

  int           checks = 0;
  int           failures = 0;
  int           strobes_a = 0, errs_a = 0, strobes_b = 0, errs_b = 0;
  logic [6:0]   last_addr_a = '0, last_addr_b = '0;
  int           base_s, base_e;
  logic [31:0]  rx;

  always #5 clk_12mhz = ~clk_12mhz;

  spi_slave_regbank u_dut_a (
    .clk_12mhz   (clk_12mhz),
    .rst         (rst),
    .spi_clk     (sck),
    .spi_mosi    (mosi),
    .spi_cs      (cs_a),
    .spi_miso    (miso_a),
    .spi_miso_oe (miso_oe_a),
    .status_in   (status_a),
    .reg_flat    (reg_flat_a),
    .wr_strobe   (wr_strobe_a),
    .wr_addr     (wr_addr_a),
    .frame_err   (frame_err_a)
  );

  spi_slave_regbank #(
    .DATA_BYTES (2),
    .CPOL       (1'b1),
    .CPHA       (1'b1),
    .AUTO_INC   (1'b1)
  ) u_dut_b (
    .clk_12mhz   (clk_12mhz),
    .rst         (rst),
    .spi_clk     (sck),
    .spi_mosi    (mosi),
    .spi_cs      (cs_b),
    .spi_miso    (miso_b),
    .spi_miso_oe (miso_oe_b),
    .status_in   (status_b),
    .reg_flat    (reg_flat_b),
    .wr_strobe   (wr_strobe_b),
    .wr_addr     (wr_addr_b),
    .frame_err   (frame_err_b)
  );

  // Pulse counters: a one-cycle pulse adds exactly one.
  always @(posedge clk_12mhz) begin
    if (wr_strobe_a) begin
      strobes_a++;
      last_addr_a = wr_addr_a;
    end
    if (frame_err_a) errs_a++;
    if (wr_strobe_b) begin
      strobes_b++;
      last_addr_b = wr_addr_b;
    end
    if (frame_err_b) errs_b++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Master transfer of nbits, MSB first; MISO is captured just before each rising
  // (sampling) edge, which both modes use. sel=1 selects the CPOL=1 instance.
  task automatic applyStimulus(input bit sel, input int nbits, input logic [31:0] tx,
                               output logic [31:0] rxd);
    rxd = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (sel) sck = 1'b0;
      mosi = tx[i];
      #H;
      rxd = {rxd[30:0], sel ? miso_b : miso_a};
      sck = 1'b1;
      #H;
      if (!sel) sck = 1'b0;
    end
  endtask

  task automatic csLow(input bit sel);
    sck = sel;
    #(2*H);
    if (sel) cs_b = 1'b0;
    else     cs_a = 1'b0;
    #(2*H);
  endtask

  task automatic csHigh(input bit sel);
    #H;
    if (sel) cs_b = 1'b1;
    else     cs_a = 1'b1;
    #(3*H);
  endtask

  initial begin
    #20;
    checkOutput("rst_regs_a", reg_flat_a, 128'h0);
    checkOutput("rst_miso_a", miso_a, 1'b0);
    checkOutput("rst_oe_a", miso_oe_a, 1'b0);
    #20 rst = 1'b0;
    #40;
    checkOutput("rst_regs_b", reg_flat_b[127:0], 128'h0);
    checkOutput("rst_strobe_a", wr_strobe_a, 1'b0);
    checkOutput("rst_wraddr_a", wr_addr_a, 7'd0);
    checkOutput("rst_err_a", frame_err_a, 1'b0);

    // Write 0x01 to reg[4].
    csLow(0);
    checkOutput("t1_oe_low", miso_oe_a, 1'b1);
    applyStimulus(0, 8, 32'h04, rx);
    applyStimulus(0, 8, 32'h01, rx);
    csHigh(0);
    checkOutput("t1_regs", reg_flat_a, 128'h01 << 32);
    checkOutput("t1_strobes", strobes_a, 1);
    checkOutput("t1_wraddr", last_addr_a, 7'd4);
    checkOutput("t1_errs", errs_a, 0);
    checkOutput("t1_oe_high", miso_oe_a, 1'b0);

    // Read reg[4] back.
    csLow(0);
    applyStimulus(0, 8, 32'h84, rx);
    applyStimulus(0, 8, 32'h00, rx);
    csHigh(0);
    checkOutput("t2_miso", rx[7:0], 8'h01);
    checkOutput("t2_regs", reg_flat_a, 128'h01 << 32);
    checkOutput("t2_strobes", strobes_a, 1);
    checkOutput("t2_errs", errs_a, 0);

    // Status word at address NUM_REGS, then an illegal write there.
    status_a = 8'h5A;
    csLow(0);
    applyStimulus(0, 8, 32'h90, rx);
    applyStimulus(0, 8, 32'h00, rx);
    csHigh(0);
    checkOutput("t3_status", rx[7:0], 8'h5A);
    checkOutput("t3_rd_errs", errs_a, 0);
    csLow(0);
    applyStimulus(0, 8, 32'h10, rx);
    applyStimulus(0, 8, 32'hFF, rx);
    csHigh(0);
    checkOutput("t3_wr_errs", errs_a, 1);
    checkOutput("t3_strobes", strobes_a, 1);
    checkOutput("t3_regs", reg_flat_a, 128'h01 << 32);

    // Without auto-increment a second word is ignored and flagged once.
    csLow(0);
    applyStimulus(0, 8, 32'h05, rx);
    applyStimulus(0, 8, 32'h11, rx);
    applyStimulus(0, 8, 32'h22, rx);
    csHigh(0);
    checkOutput("t3b_reg5", reg_flat_a[5*8 +: 8], 8'h11);
    checkOutput("t3b_strobes", strobes_a, 2);
    checkOutput("t3b_errs", errs_a, 2);

    // CS rises after 12 bits: partial word dropped, one error, FSM back to idle.
    csLow(0);
    applyStimulus(0, 8, 32'h03, rx);
    applyStimulus(0, 4, 32'hC, rx);
    csHigh(0);
    checkOutput("t4_reg3", reg_flat_a[3*8 +: 8], 8'h00);
    checkOutput("t4_errs", errs_a, 3);
    checkOutput("t4_strobes", strobes_a, 2);
    csLow(0);
    applyStimulus(0, 8, 32'h03, rx);
    applyStimulus(0, 8, 32'h3C, rx);
    csHigh(0);
    checkOutput("t4_reg3_next", reg_flat_a[3*8 +: 8], 8'h3C);
    checkOutput("t4_errs_next", errs_a, 3);

    // Instance B: mode 3, 16-bit words, burst write then burst readback.
    csLow(1);
    applyStimulus(1, 8, 32'h02, rx);
    applyStimulus(1, 16, 32'hAA55, rx);
    applyStimulus(1, 16, 32'h1234, rx);
    csHigh(1);
    checkOutput("t5_reg2", reg_flat_b[2*16 +: 16], 16'hAA55);
    checkOutput("t5_reg3", reg_flat_b[3*16 +: 16], 16'h1234);
    checkOutput("t5_strobes", strobes_b, 2);
    checkOutput("t5_wraddr", last_addr_b, 7'd3);
    csLow(1);
    applyStimulus(1, 8, 32'h82, rx);
    applyStimulus(1, 32, 32'h0, rx);
    csHigh(1);
    checkOutput("t5_readback", rx, 32'hAA551234);
    checkOutput("t5_errs", errs_b, 0);

    // Reset in the middle of a data word.
    csLow(0);
    applyStimulus(0, 8, 32'h05, rx);
    applyStimulus(0, 4, 32'h7, rx);
    base_s = strobes_a;
    base_e = errs_a;
    #20 rst = 1'b1;
    #40;
    checkOutput("t6_regs_a", reg_flat_a, 128'h0);
    checkOutput("t6_regs_b", reg_flat_b[2*16 +: 32], 32'h0);
    checkOutput("t6_miso", miso_a, 1'b0);
    checkOutput("t6_oe", miso_oe_a, 1'b0);
    rst = 1'b0;
    csHigh(0);
    csLow(0);
    applyStimulus(0, 8, 32'h05, rx);
    applyStimulus(0, 8, 32'h77, rx);
    csHigh(0);
    checkOutput("t6_regs_after", reg_flat_a, 128'h77 << 40);
    checkOutput("t6_strobes", strobes_a - base_s, 1);
    checkOutput("t6_errs", errs_a - base_e, 0);
    checkOutput("t6_wraddr", last_addr_a, 7'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
